// File: rtl/controller_if.sv
// controller_if: instruction/flag inputs and registered decode outputs of the controller.
interface controller_if;
  logic [31:0] IR_in;
  logic [3:0]  Flags_in;
  logic        Wen_ARd;
  logic        Wen_Dmem;
  logic        Wen_Flags;
  logic [4:0]  cmd;
  logic        select_X;
  logic        select_Y;
  logic [1:0]  select_src1;
  logic [2:0]  select_src2shift;
  modport master (
    output IR_in, Flags_in,
    input  Wen_ARd, Wen_Dmem, Wen_Flags, cmd, select_X, select_Y, select_src1, select_src2shift
  );
  modport slave (
    input  IR_in, Flags_in,
    output Wen_ARd, Wen_Dmem, Wen_Flags, cmd, select_X, select_Y, select_src1, select_src2shift
  );
endinterface

// File: rtl/controller.sv
// controller: single-cycle ARM-style instruction decoder with registered control outputs.
module controller (
  input logic        CLOCK_50,
  input logic        rst_n,
  controller_if.slave bus
);
  logic       n, z, c, v;
  logic [1:0] cls;
  logic [3:0] op;
  logic       i_bit, s_bit, pass;
  logic [15:0] cond_tbl;
  logic       d_ard, d_dmem, d_flags, d_x, d_y;
  logic [4:0] d_cmd;
  logic [1:0] d_src1;
  logic [2:0] d_s2;
  assign {n, z, c, v} = bus.Flags_in;
  assign cls   = bus.IR_in[27:26];
  assign i_bit = bus.IR_in[25];
  assign op    = bus.IR_in[24:21];
  assign s_bit = bus.IR_in[20];
  // condition table indexed by cond, entry 15 down to entry 0
  assign cond_tbl = {1'b0, 1'b1, z | (n != v), !z & (n == v), n != v, n == v, !c | z, c & !z,
                     !v, v, !n, n, !c, c, !z, z};
  assign pass = cond_tbl[bus.IR_in[31:28]];
  always_comb begin
    d_ard   = 1'b0;
    d_dmem  = 1'b0;
    d_flags = 1'b0;
    d_x     = 1'b0;
    d_y     = 1'b0;
    d_cmd   = 5'b00000;
    d_src1  = 2'b00;
    d_s2    = 3'b000;
    case (cls)
      2'b00: begin
        d_cmd   = {1'b0, op};
        d_s2    = {2'b00, i_bit};
        d_ard   = pass & (op[3:2] != 2'b10);
        d_flags = pass & s_bit;
      end
      2'b01: begin
        d_cmd  = 5'b00100;
        d_s2   = i_bit ? 3'b011 : 3'b010;
        d_x    = !i_bit;
        d_ard  = pass & !i_bit;
        d_dmem = pass & i_bit;
      end
      2'b10: begin
        d_cmd  = 5'b00100;
        d_src1 = 2'b10;
        d_s2   = 3'b101;
        d_y    = pass;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      bus.Wen_ARd          <= 1'b0;
      bus.Wen_Dmem         <= 1'b0;
      bus.Wen_Flags        <= 1'b0;
      bus.cmd              <= 5'b00000;
      bus.select_X         <= 1'b0;
      bus.select_Y         <= 1'b0;
      bus.select_src1      <= 2'b00;
      bus.select_src2shift <= 3'b000;
    end else begin
      bus.Wen_ARd          <= d_ard;
      bus.Wen_Dmem         <= d_dmem;
      bus.Wen_Flags        <= d_flags;
      bus.cmd              <= d_cmd;
      bus.select_X         <= d_x;
      bus.select_Y         <= d_y;
      bus.select_src1      <= d_src1;
      bus.select_src2shift <= d_s2;
    end
  end
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed vectors, condition sweep, random vectors and reset/latency sequences.
module tb_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  controller_if bif ();
  controller dut (.CLOCK_50(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  // packed as {Wen_ARd, Wen_Dmem, Wen_Flags, cmd[4:0], X, Y, src1[1:0], src2shift[2:0]}
  typedef struct {
    logic [31:0] ir;
    logic [3:0]  fl;
    logic [14:0] exp;
  } vec_t;
  vec_t vecs [10];
  function automatic logic [14:0] outs();
    return {bif.Wen_ARd, bif.Wen_Dmem, bif.Wen_Flags, bif.cmd, bif.select_X, bif.select_Y,
            bif.select_src1, bif.select_src2shift};
  endfunction
  // ARM-style evaluation: base test chosen by cond[3:1], inverted by cond[0]
  function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] fl);
    bit nf, zf, cf, vf, base;
    nf = fl[3]; zf = fl[2]; cf = fl[1]; vf = fl[0];
    case (cond[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = (nf == vf);
      3'd6: base = !zf && (nf == vf);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction
  function automatic logic [14:0] ref_model(input logic [31:0] ir, input logic [3:0] fl);
    bit p, ard, dm, wf, x, y;
    int cmdv, s1, s2, op;
    p = ref_pass(ir[31:28], fl);
    op = int'(ir[24:21]);
    ard = 0; dm = 0; wf = 0; x = 0; y = 0; cmdv = 0; s1 = 0; s2 = 0;
    if (ir[27:26] == 2'd0) begin
      cmdv = op;
      s2 = ir[25] ? 1 : 0;
      ard = p && !(op >= 8 && op <= 11);
      wf = p && ir[20];
    end else if (ir[27:26] == 2'd1) begin
      cmdv = 4;
      if (ir[25]) begin s2 = 3; dm = p; end
      else begin s2 = 2; x = 1; ard = p; end
    end else if (ir[27:26] == 2'd2) begin
      cmdv = 4; s1 = 2; s2 = 5; y = p;
    end
    return {ard, dm, wf, 5'(cmdv), x, y, 2'(s1), 3'(s2)};
  endfunction
  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] got;
    got = outs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask
  task automatic apply(input logic [31:0] ir, input logic [3:0] fl);
    @(negedge clk);
    bif.IR_in = ir;
    bif.Flags_in = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{32'hE0810312, 4'b0000, 15'b1_0_0_00100_0_0_00_000};
    vecs[1] = '{32'hE0810104, 4'b0000, 15'b1_0_0_00100_0_0_00_000};
    vecs[2] = '{32'h02510002, 4'b0100, 15'b1_0_1_00010_0_0_00_001};
    vecs[3] = '{32'h12420002, 4'b0100, 15'b0_0_0_00010_0_0_00_001};
    vecs[4] = '{32'h04110003, 4'b0100, 15'b1_0_0_00100_1_0_00_010};
    vecs[5] = '{32'h06010012, 4'b0100, 15'b0_1_0_00100_0_0_00_011};
    vecs[6] = '{32'h8A000008, 4'b0010, 15'b0_0_0_00100_0_1_10_101};
    vecs[7] = '{32'h8A000008, 4'b0000, 15'b0_0_0_00100_0_0_10_101};
    vecs[8] = '{32'hEC000000, 4'b1111, 15'b0_0_0_00000_0_0_00_000};
    vecs[9] = '{32'hE1500000, 4'b0000, 15'b0_0_1_01010_0_0_00_000};
    bif.IR_in = 32'hE0810312;
    bif.Flags_in = 4'b0000;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 15'd0);
    @(posedge clk);
    #1 check("reset_held", 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_before_edge", 15'd0);
    @(posedge clk);
    #1 check("first_edge_after_reset", vecs[0].exp);
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].ir, vecs[i].fl);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    // latency: a new IR must not reach the outputs before the next rising edge
    apply(vecs[6].ir, vecs[6].fl);
    @(negedge clk);
    bif.IR_in = vecs[5].ir;
    bif.Flags_in = vecs[5].fl;
    #1 check("latency_hold", vecs[6].exp);
    @(posedge clk);
    #1 check("latency_update", vecs[5].exp);
    for (int cc = 0; cc < 16; cc++)
      for (int f = 0; f < 16; f++) begin
        apply({4'(cc), 28'h0810312}, 4'(f));
        check($sformatf("cond%0d_flags%0d", cc, f), ref_model({4'(cc), 28'h0810312}, 4'(f)));
      end
    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      logic [3:0] fr;
      r = $urandom;
      fr = 4'($urandom_range(0, 15));
      apply(r, fr);
      check($sformatf("rand%0d_ir%08h", k, r), ref_model(r, fr));
    end
    // mid-stream reset with a write-enabling decode pending
    apply(vecs[4].ir, vecs[4].fl);
    @(negedge clk);
    bif.IR_in = vecs[2].ir;
    bif.Flags_in = vecs[2].fl;
    #2 rst_n = 1'b0;
    #1 check("midstream_reset_immediate", 15'd0);
    @(posedge clk);
    #1 check("midstream_reset_no_pulse", 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reload_after_midstream_reset", vecs[2].exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLOCK_50  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 IR_in  input  32  instruction word: cond[31:28], class[27:26], I/offset-type[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], operand2/offset[11:0], branch imm24[23:0].
REQ-006 Flags_in  input  4  current condition flags {N,Z,C,V}.
REQ-007 Wen_ARd  output  1  register-file write enable for Rd.
REQ-008 Wen_Dmem  output  1  data-memory write enable.
REQ-009 Wen_Flags  output  1  flag-register write enable.
REQ-010 cmd  output  5  ALU command.
REQ-011 select_X  output  1  write-back source: 0 = ALU result, 1 = memory read data.
REQ-012 select_Y  output  1  next-PC select: 0 = PC+4, 1 = branch target.
REQ-013 select_src1  output  2  ALU operand-1 select: 00 = Rn, 10 = PC; 01 and 11 are never driven.
REQ-014 select_src2shift  output  3  operand-2 source/shift select.

Function
REQ-015 All outputs SHALL be registered: the decode of IR_in/Flags_in sampled at rising edge k appears on the outputs after edge k, giving a latency of 1 cycle; outputs hold between edges.
REQ-016 condPass SHALL be evaluated on Flags_in per standard ARM cond: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never.
REQ-017 Data-processing instructions (class 00):
- cmd = {0, opcode}.
- select_src1 = 00.
- select_src2shift = 001 if I=1 (rotated imm8), else 000 (Rm shifted by immediate or by Rs).
- Wen_ARd = condPass & opcode not in {1000, 1001, 1010, 1011}.
- Wen_Flags = condPass & S.
- Wen_Dmem = 0; select_X = 0; select_Y = 0.
REQ-018 Memory instructions (class 01):
- cmd = 00100 (address = Rn + offset); select_src1 = 00; Wen_Flags = 0; select_Y = 0.
- IR[25]=0: LDR with imm12 offset. select_src2shift = 010, select_X = 1, Wen_ARd = condPass, Wen_Dmem = 0.
- IR[25]=1: STR with register offset Rm. select_src2shift = 011, select_X = 0, Wen_ARd = 0, Wen_Dmem = condPass.
REQ-019 Branch (class 10):
- cmd = 00100; select_src1 = 10; select_src2shift = 101 (sign-extended imm24 << 2).
- select_Y = condPass.
- All write enables 0; select_X = 0.
REQ-020 Class 11 (undefined) SHALL produce the same outputs as reset.
REQ-021 select_src2shift codes 100, 110 and 111 SHALL never be driven.
REQ-022 A failing condition SHALL suppress only the write enables and select_Y; cmd and the select fields still follow the decode.

Reset
REQ-023 While rst_n = 0, all outputs SHALL be 0 immediately, asynchronously (cmd = 00000, selects 0, all enables 0).
REQ-024 On rst_n deassertion, the first rising edge SHALL load the decode of the current IR_in.
REQ-025 Reset asserted mid-stream SHALL discard the pending decode; no write enable may pulse after assertion.

Verification
REQ-026 Flags 0000, IR 0xE0810312 (ADD R0,R1,R2,LSL R3) -> Wen_ARd 1, Wen_Dmem 0, Wen_Flags 0, cmd 00100, X 0, Y 0, src1 00, src2shift 000; IR 0xE0810104 gives the same.
REQ-027 Flags 0100, IR 0x02510002 (SUBEQS R0,R1,#2) -> Wen_ARd 1, Wen_Flags 1, cmd 00010, src2shift 001; IR 0x12420002 (SUBNE) -> Wen_ARd 0, Wen_Flags 0, cmd 00010, src2shift 001.
REQ-028 Flags 0100, IR 0x04110003 (LDR) -> Wen_ARd 1, X 1, cmd 00100, src2shift 010; IR 0x06010012 (STR) -> Wen_ARd 0, Wen_Dmem 1, X 0, src2shift 011.
REQ-029 IR 0x8A000008 (BHI): Flags 0010 -> Y 1, src1 10, src2shift 101, all enables 0; Flags 0000 -> Y 0, other outputs unchanged.
REQ-030 Latency and reset: a new IR appears on the outputs only after the next rising edge; asserting rst_n = 0 between edges forces all outputs to 0 at once.
REQ-031 Condition sweep: all 16 cond codes against all 16 flag combinations with AL-class ADD -> Wen_ARd matches the REQ-016 table; cond 1111 never writes.
